// File: rtl/key_pkg.sv
// Shared types and width helpers for the key matrix scanner.
package key_pkg;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_PRESS,
        EV_RELEASE
    } key_ev_t;

    // Bits needed to index n items; never less than one bit.
    function automatic int unsigned code_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_frame_debounce.sv
// Accepts a scan frame once it has matched the previous raw frame often enough.
module key_frame_debounce
    import key_pkg::*;
#(
    parameter int unsigned N        = 16,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] frame_i,
    input  logic         frame_done_i,
    output logic [N-1:0] frame_acc_c_o,
    output logic         accept_c_o
);

    localparam int unsigned SW = code_width(DEBOUNCE + 1);

    logic [N-1:0]  raw_q, raw_d;
    logic [SW-1:0] stable_q, stable_d;

    // Stable count saturates so a held frame keeps being re-accepted every frame.
    always_comb begin
        raw_d    = raw_q;
        stable_d = stable_q;
        if (frame_done_i) begin
            raw_d = frame_i;
            if (frame_i == raw_q) begin
                stable_d = (stable_q == SW'(DEBOUNCE)) ? stable_q : stable_q + SW'(1);
            end else begin
                stable_d = '0;
            end
        end
    end

    assign accept_c_o    = frame_done_i && (stable_d == SW'(DEBOUNCE));
    assign frame_acc_c_o = frame_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q    <= '0;
            stable_q <= '0;
        end else begin
            raw_q    <= raw_d;
            stable_q <= stable_d;
        end
    end

endmodule

// File: rtl/key_matrix_scan.sv
// Row-scanned key matrix reader: synchronises columns, debounces whole frames,
// and reports single-key press/release events.
module key_matrix_scan
    import key_pkg::*;
#(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic [ROWS-1:0]                     row,
    input  logic [COLS-1:0]                     col,
    output logic [code_width(ROWS*COLS)-1:0]    key_code,
    output logic                                key_valid,
    output logic                                key_down,
    output logic                                key_release
);

    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned KW = code_width(N);
    localparam int unsigned CW = code_width(SCAN_DIV);
    localparam int unsigned IW = code_width(ROWS);

    logic [COLS-1:0] sync1_q, sync2_q;
    logic [CW-1:0]   slot_q, slot_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [ROWS-1:0] row_q, row_d;
    logic [N-1:0]    frame_q, frame_d;
    logic            tick_c, frame_done_c;

    logic [N-1:0]    frame_acc_c;
    logic            accept_c;

    logic [KW-1:0]   key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            key_down_q, key_down_d;
    logic            key_release_q, key_release_d;

    logic [1:0]      ones_c;
    logic [KW-1:0]   code_c;
    key_ev_t         ev_c;

    assign tick_c       = (slot_q == CW'(SCAN_DIV - 1));
    assign frame_done_c = tick_c && (idx_q == IW'(ROWS - 1));

    // Slot timing, row rotation and capture of the active row's columns.
    always_comb begin
        slot_d  = tick_c ? '0 : slot_q + CW'(1);
        idx_d   = idx_q;
        row_d   = row_q;
        frame_d = frame_q;
        if (tick_c) begin
            idx_d    = (idx_q == IW'(ROWS - 1)) ? '0 : idx_q + IW'(1);
            row_d[0] = row_q[ROWS-1];
            for (int r = 1; r < ROWS; r++) begin
                row_d[r] = row_q[r-1];
            end
            for (int r = 0; r < ROWS; r++) begin
                if (idx_q == IW'(r)) begin
                    frame_d[r*COLS +: COLS] = ~sync2_q;
                end
            end
        end
    end

    key_frame_debounce #(
        .N        (N),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk           (clk),
        .rst           (rst),
        .frame_i       (frame_d),
        .frame_done_i  (frame_done_c),
        .frame_acc_c_o (frame_acc_c),
        .accept_c_o    (accept_c)
    );

    // Saturating 0/1/many popcount and OR-based one-hot encode of the accepted frame.
    always_comb begin
        ones_c = 2'd0;
        code_c = '0;
        for (int i = 0; i < N; i++) begin
            if (frame_acc_c[i]) begin
                ones_c = (ones_c == 2'd2) ? 2'd2 : ones_c + 2'd1;
                code_c = code_c | KW'(i);
            end
        end
    end

    always_comb begin
        ev_c = EV_NONE;
        if (accept_c) begin
            if (ones_c == 2'd1 && (!key_down_q || code_c != key_code_q)) begin
                ev_c = EV_PRESS;
            end else if (ones_c == 2'd0 && key_down_q) begin
                ev_c = EV_RELEASE;
            end
        end
    end

    always_comb begin
        key_code_d    = key_code_q;
        key_down_d    = key_down_q;
        key_valid_d   = 1'b0;
        key_release_d = 1'b0;
        case (ev_c)
            EV_PRESS: begin
                key_code_d  = code_c;
                key_down_d  = 1'b1;
                key_valid_d = 1'b1;
            end
            EV_RELEASE: begin
                key_down_d    = 1'b0;
                key_release_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            slot_q        <= '0;
            idx_q         <= '0;
            row_q         <= ~ROWS'(1);
            frame_q       <= '0;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_down_q    <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            sync1_q       <= col;
            sync2_q       <= sync1_q;
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            row_q         <= row_d;
            frame_q       <= frame_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_down_q    <= key_down_d;
            key_release_q <= key_release_d;
        end
    end

    assign row         = row_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_down    = key_down_q;
    assign key_release = key_release_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Scoreboarded bench for key_matrix_scan with a frame-level reference model.
module tb_key_matrix_scan;
    import key_pkg::*;

    localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 2, N = 16, FRAME = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row, col, key_code;
    logic       key_valid, key_down, key_release;
    logic [15:0] pressed = '0;

    always #5 clk = ~clk;

    key_matrix_scan #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code),
        .key_valid(key_valid), .key_down(key_down), .key_release(key_release)
    );

    // Physical matrix: a pressed switch pulls its column low while its row is driven.
    always_comb begin
        col = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (row[r] == 1'b0 && pressed[r*COLS+c]) col[c] = 1'b0;
    end

    typedef struct { key_ev_t ev; int code; longint cyc; } exp_t;
    exp_t exp_q[$];

    int     checks = 0, errors = 0;
    longint gcyc = 0;
    int     n_press = 0, n_rel = 0;
    longint last_press_cyc = 0;

    // Reference model state
    int          t = 0;
    logic [15:0] h1, h2, s, fr, raw;
    int          stable, kc, nset, code, r;
    bit          kd, started = 0;

    function automatic void chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, gcyc);
        end
    endfunction

    // Model: t counts non-reset edges; each slot ends at t%SCAN_DIV==SCAN_DIV-1 and
    // sees the switch state from two edges earlier (synchroniser).
    always @(posedge clk) begin
        gcyc++;
        if (rst) begin
            t = 0; h1 = '0; h2 = '0; fr = '0; raw = '0;
            stable = 0; kd = 0; kc = 0; started = 1;
        end else begin
            s = h2; h2 = h1; h1 = pressed;
            if (t % SCAN_DIV == SCAN_DIV - 1) begin
                r = (t / SCAN_DIV) % ROWS;
                fr[r*COLS +: COLS] = s[r*COLS +: COLS];
                if (r == ROWS - 1) begin
                    if (fr == raw) stable = (stable < DEBOUNCE) ? stable + 1 : DEBOUNCE;
                    else stable = 0;
                    raw = fr;
                    if (stable == DEBOUNCE) begin
                        nset = $countones(fr);
                        code = 0;
                        for (int i = 0; i < N; i++) if (fr[i]) code = i;
                        if (nset == 1 && (!kd || code != kc)) begin
                            exp_q.push_back('{EV_PRESS, code, gcyc});
                            kc = code; kd = 1;
                        end else if (nset == 0 && kd) begin
                            exp_q.push_back('{EV_RELEASE, kc, gcyc});
                            kd = 0;
                        end
                    end
                end
            end
            t++;
        end
    end

    // Monitor: compares outputs and pops expected events as the DUT presents them.
    always @(negedge clk) begin
        exp_t    e;
        key_ev_t act;
        logic [3:0] exp_row;
        if (started) begin
            exp_row = ~(4'b0001 << ((t / SCAN_DIV) % ROWS));
            chk(row == exp_row, "row", row, exp_row);
            chk(!(key_valid && key_release), "valid_release_coincident", {key_valid, key_release}, 0);
            if (key_valid || key_release) begin
                act = key_valid ? EV_PRESS : EV_RELEASE;
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_event", int'(act), int'(EV_NONE));
                end else begin
                    e = exp_q.pop_front();
                    chk(act == e.ev, "event_kind", int'(act), int'(e.ev));
                    chk(key_code == 4'(e.code), "event_code", key_code, e.code);
                    chk(gcyc == e.cyc, "event_cycle", gcyc, e.cyc);
                end
                if (key_valid) begin n_press++; last_press_cyc = gcyc; end
                if (key_release) n_rel++;
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= gcyc) begin
                e = exp_q.pop_front();
                chk(0, "missed_event", 0, int'(e.ev));
            end
            chk(key_down == kd, "key_down", key_down, kd);
            chk(key_code == 4'(kc), "key_code", key_code, kc);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic align_frame();
        for (int i = 0; i < FRAME && (t % FRAME) != 0; i++) wait_cyc(1);
        chk((t % FRAME) == 0, "frame_align", t % FRAME, 0);
    endtask

    initial begin
        int     p0, r0, sel, hold;
        longint c0;
        logic [15:0] m;

        // 1: reset, then free run (row rotation checked every cycle by the monitor)
        rst = 1'b1;
        wait_cyc(3);
        chk(row == 4'b1110, "reset_row", row, 4'b1110);
        chk({key_valid, key_down, key_release} == 3'b000, "reset_outputs", {key_valid, key_down, key_release}, 0);
        chk(key_code == 4'd0, "reset_code", key_code, 0);
        rst = 1'b0;
        wait_cyc(40);

        // 2: clean press r2c1 at frame start
        align_frame();
        p0 = n_press; c0 = gcyc;
        pressed = 16'(1) << 9;
        wait_cyc(4 * FRAME);
        chk(n_press - p0 == 1, "t2_press_count", n_press - p0, 1);
        chk(key_code == 4'd9, "t2_code", key_code, 9);
        chk(key_down == 1'b1, "t2_key_down", key_down, 1);
        chk(last_press_cyc - c0 <= 3 * FRAME + 1, "t2_latency", last_press_cyc - c0, 3 * FRAME + 1);

        // 4: release
        r0 = n_rel;
        pressed = '0;
        wait_cyc(4 * FRAME);
        chk(n_rel - r0 == 1, "t4_release_count", n_rel - r0, 1);
        chk(key_down == 1'b0, "t4_key_down", key_down, 0);
        chk(key_code == 4'd9, "t4_code_held", key_code, 9);

        // 3: bounce r2c1 every 10 cycles for 100 cycles, then hold
        align_frame();
        wait_cyc(5);
        p0 = n_press;
        for (int i = 0; i < 10; i++) begin
            pressed = (i % 2 == 0) ? (16'(1) << 9) : 16'(0);
            wait_cyc(10);
        end
        chk(n_press == p0, "t3_no_event_bouncing", n_press - p0, 0);
        pressed = 16'(1) << 9;
        wait_cyc(80);
        chk(n_press - p0 == 1, "t3_single_press", n_press - p0, 1);
        chk(key_code == 4'd9, "t3_code", key_code, 9);
        pressed = '0;
        wait_cyc(4 * FRAME);

        // 5: ghost r0c0 + r1c3, then release r1c3
        p0 = n_press;
        pressed = 16'h0081;
        wait_cyc(5 * FRAME);
        chk(n_press == p0, "t5_ghost_no_press", n_press - p0, 0);
        chk(key_down == 1'b0, "t5_ghost_key_down", key_down, 0);
        pressed = 16'h0001;
        wait_cyc(4 * FRAME);
        chk(n_press - p0 == 1, "t5_press_after_ghost", n_press - p0, 1);
        chk(key_code == 4'd0, "t5_code", key_code, 0);

        // 6: reset mid-frame while held
        wait_cyc(FRAME + 5);
        r0 = n_rel; p0 = n_press;
        rst = 1'b1;
        wait_cyc(1);
        chk(key_down == 1'b0, "t6_reset_key_down", key_down, 0);
        chk(row == 4'b1110, "t6_reset_row", row, 4'b1110);
        rst = 1'b0;
        wait_cyc(4 * FRAME);
        chk(n_rel == r0, "t6_no_release", n_rel - r0, 0);
        chk(n_press - p0 == 1, "t6_fresh_press", n_press - p0, 1);
        pressed = '0;
        wait_cyc(4 * FRAME);

        // Random phase: single keys, idle and multi-press with random hold times
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0:       m = '0;
                3:       m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
                default: m = 16'(1) << $urandom_range(0, 15);
            endcase
            pressed = m;
            hold = $urandom_range(6, 100);
            wait_cyc(hold);
        end
        pressed = '0;
        wait_cyc(6 * FRAME);
        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
